// File: rtl/ce_input_buf_s_axi_regs.sv
// ============================================================================
// ce_input_buf_s_axi_regs
// ----------------------------------------------------------------------------
// AXI4-Lite responder holding the four 32-bit static configuration registers
// of the CE input buffer (byte offsets 0x0, 0x4, 0x8, 0xC). Single-beat
// writes and reads only. Each committed write to an implemented register
// produces a one-cycle one-hot pulse on cfg_wr_stb in the following cycle.
//
// Build option:
//   CE_REGS_SLVERR_EN  defined   -> accesses to word slots 4-7 answer SLVERR
//                      undefined -> every access answers OKAY
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET    clock, asynchronous active-high reset
//   S_AXI_AW*                   write address channel (AWPROT ignored)
//   S_AXI_W*                    write data channel, WSTRB byte enables
//   S_AXI_B*                    write response channel
//   S_AXI_AR*                   read address channel (ARPROT ignored)
//   S_AXI_R*                    read data channel
//   cfg_reg0..cfg_reg3          current register contents
//   cfg_wr_stb[3:0]             one-hot write-commit pulse, one cycle
// ============================================================================
module ce_input_buf_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg_reg3,
    output logic [3:0]                        cfg_wr_stb
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NREG   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NREG - 1);
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

`ifdef CE_REGS_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

    // ------------------------------------------------------------------
    // Byte-lane merge: keep old bytes where the strobe is low.
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] f_merge(
        input logic [DW-1:0]     old_val,
        input logic [DW-1:0]     new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_live stays low through reset and for the first edge after it, so
    // every READY reads 0 while reset is asserted without routing the
    // reset input combinationally to an output.
    logic                r_live;

    logic                r_aw_held;
    logic [IDX_W-1:0]    r_aw_idx;
    logic                r_w_held;
    logic [DW-1:0]       r_w_data;
    logic [STRB_W-1:0]   r_w_strb;

    logic                r_bvalid;
    logic [1:0]          r_bresp;

    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [DW-1:0]       r_rdata;

    logic [DW-1:0]       r_reg [NREG];
    logic [NREG-1:0]     r_wr_stb;

    // ------------------------------------------------------------------
    // Handshakes and write-commit decode
    // ------------------------------------------------------------------
    logic                w_awready;
    logic                w_wready;
    logic                w_arready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [DW-1:0]       w_wr_data;
    logic [STRB_W-1:0]   w_wr_strb;
    logic                w_wr_mapped;
    logic [NREG-1:0]     w_wr_sel;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [DW-1:0]       w_rd_data;
    logic [1:0]          w_rd_resp;
    logic                w_unused;

    assign w_awready = r_live && !r_aw_held && !r_bvalid;
    assign w_wready  = r_live && !r_w_held  && !r_bvalid;
    assign w_arready = r_live && !r_rvalid;

    assign w_aw_hs = S_AXI_AWVALID && w_awready;
    assign w_w_hs  = S_AXI_WVALID  && w_wready;
    assign w_ar_hs = S_AXI_ARVALID && w_arready;

    // A held beat takes priority over the bus: the bus side cannot
    // handshake while its buffer is full anyway.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_held  ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_w_strb : S_AXI_WSTRB;

    assign w_commit    = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_mapped = (w_wr_idx <= LAST_IDX);

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wr_sel[i] = w_commit && (w_wr_idx == IDX_W'(i));
        end
    end

    // Read mux samples the registers before any same-edge write lands,
    // so a colliding read returns the pre-write value.
    always_comb begin
        w_rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_rd_data = '0;
        w_rd_resp = RESP_UNMAPPED;
        for (int i = 0; i < NREG; i++) begin
            if (w_rd_idx == IDX_W'(i)) begin
                w_rd_data = r_reg[i];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Write channel: holding buffers, commit, response
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_stb  <= '0;
        end else begin
            r_live   <= 1'b1;
            r_wr_stb <= w_wr_sel;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NREG; i++) begin
                r_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_sel[i]) begin
                    r_reg[i] <= f_merge(r_reg[i], w_wr_data, w_wr_strb);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_resp;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    assign cfg_reg0   = r_reg[0];
    assign cfg_reg1   = r_reg[1];
    assign cfg_reg2   = r_reg[2];
    assign cfg_reg3   = r_reg[3];
    assign cfg_wr_stb = r_wr_stb;

endmodule

// File: tb/tb_ce_input_buf_s_axi_regs.sv
// ============================================================================
// tb_ce_input_buf_s_axi_regs
// ----------------------------------------------------------------------------
// Scoreboard bench for ce_input_buf_s_axi_regs. The stimulus process updates
// a word-array model of the register bank and queues the expected B/R
// responses and write strobes; a monitor pops and compares on every
// handshake / strobe. Define CE_REGS_SLVERR_EN to match the DUT build.
// ============================================================================
module tb_ce_input_buf_s_axi_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  S_AXI_AWADDR  = '0;
    logic [2:0]  S_AXI_AWPROT  = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA   = '0;
    logic [3:0]  S_AXI_WSTRB   = '0;
    logic        S_AXI_WVALID  = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY  = 1'b0;
    logic [4:0]  S_AXI_ARADDR  = '0;
    logic [2:0]  S_AXI_ARPROT  = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY  = 1'b0;
    logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
    logic [3:0]  cfg_wr_stb;

    ce_input_buf_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .cfg_reg0     (cfg_reg0),
        .cfg_reg1     (cfg_reg1),
        .cfg_reg2     (cfg_reg2),
        .cfg_reg3     (cfg_reg3),
        .cfg_wr_stb   (cfg_wr_stb)
    );

`ifdef CE_REGS_SLVERR_EN
    localparam logic [1:0] UNMAP = 2'b10;
`else
    localparam logic [1:0] UNMAP = 2'b00;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [31:0] m [4];
    rexp_t       rq [$];
    logic [1:0]  bq [$];
    logic [3:0]  sq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mrd(input logic [4:0] a);
        int idx;
        idx = int'(a / 4);
        return (idx < 4) ? m[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] mresp(input logic [4:0] a);
        return (int'(a / 4) < 4) ? 2'b00 : UNMAP;
    endfunction

    task automatic mwr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] v;
        idx = int'(a / 4);
        if (idx < 4) begin
            v = m[idx];
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            m[idx] = v;
        end
    endtask

    // ---------------- monitor ----------------
    rexp_t      mon_re;
    logic [1:0] mon_be;
    logic [3:0] mon_se;

    always @(negedge clk) begin
        if (!rst) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                else begin
                    mon_be = bq.pop_front();
                    chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, mon_be});
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
                else begin
                    mon_re = rq.pop_front();
                    chk("rdata", S_AXI_RDATA, mon_re.d);
                    chk("rresp", {30'd0, S_AXI_RRESP}, {30'd0, mon_re.r});
                end
            end
            if (cfg_wr_stb != 4'd0) begin
                if (sq.size() == 0) chk("stb_unexpected", {28'd0, cfg_wr_stb}, 32'd0);
                else begin
                    mon_se = sq.pop_front();
                    chk("cfg_wr_stb", {28'd0, cfg_wr_stb}, {28'd0, mon_se});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic get_b(input int dly);
        for (int i = 0; i < 50; i++) begin
            if (S_AXI_BVALID) break;
            @(posedge clk); #1;
        end
        chk("bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
        for (int k = 0; k < dly; k++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", {31'd0, S_AXI_BVALID}, 32'd1);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic get_r(input int dly);
        for (int i = 0; i < 50; i++) begin
            if (S_AXI_RVALID) break;
            @(posedge clk); #1;
        end
        chk("rvalid_seen", {31'd0, S_AXI_RVALID}, 32'd1);
        for (int k = 0; k < dly; k++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", {31'd0, S_AXI_RVALID}, 32'd1);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // One transaction: optional write (AW/W each delayed by its own lag),
    // optional read issued at cycle 0; negative response delay = leave the
    // response pending.
    task automatic xact(input bit dw, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input int aw_lag, input int w_lag,
                        input bit dr, input logic [4:0] ra, input int bdly, input int rdly);
        bit aw_done, w_done, ar_done, aw_f, w_f, ar_f;
        int cyc;
        rexp_t re;
        if (dr) begin
            re.d = mrd(ra);
            re.r = mresp(ra);
            rq.push_back(re);
        end
        if (dw) begin
            bq.push_back(mresp(wa));
            if (int'(wa / 4) < 4) sq.push_back(4'b0001 << (wa / 4));
            mwr(wa, wd, ws);
        end
        aw_done = !dw; w_done = !dw; ar_done = !dr; cyc = 0;
        while (!(aw_done && w_done && ar_done) && cyc < 200) begin
            if (!aw_done && cyc >= aw_lag) begin S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = wa; end
            if (!w_done && cyc >= w_lag) begin S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd; S_AXI_WSTRB = ws; end
            if (!ar_done) begin S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = ra; end
            @(negedge clk);
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            ar_f = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge clk); #1;
            if (aw_f) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_f)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
            if (ar_f) begin S_AXI_ARVALID = 1'b0; ar_done = 1'b1; end
            cyc++;
        end
        if (!(aw_done && w_done && ar_done)) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        end
        if (dw && bdly >= 0) get_b(bdly);
        if (dr && rdly >= 0) get_r(rdly);
    endtask

    task automatic chk_cfg();
        chk("cfg_reg0", cfg_reg0, m[0]);
        chk("cfg_reg1", cfg_reg1, m[1]);
        chk("cfg_reg2", cfg_reg2, m[2]);
        chk("cfg_reg3", cfg_reg3, m[3]);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    logic [31:0] seq_d [4];

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 32'h0;

        // ---- reset held 500 ns ----
        for (int k = 0; k < 5; k++) begin
            repeat (10) @(negedge clk);
            chk("rst_handshake_outs",
                {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
            chk("rst_cfg", cfg_reg0 | cfg_reg1 | cfg_reg2 | cfg_reg3 | {28'd0, cfg_wr_stb}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'(4*i), 0, 0);
        chk_cfg();

        // ---- sequential write / read-back ----
        seq_d[0] = 32'h0101FFFF; seq_d[1] = 32'hABCD0001;
        seq_d[2] = 32'hDEAD0011; seq_d[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) begin
            xact(1, 5'(4*i), seq_d[i], 4'hF, 0, 0, 0, 5'd0, 0, 0);
            xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'(4*i), 0, 0);
        end
        chk_cfg();

        // ---- split channels: W five cycles ahead of AW ----
        xact(1, 5'h08, 32'h12345678, 4'hF, 5, 0, 0, 5'd0, 3, 0);
        chk("split_cfg_reg2", cfg_reg2, 32'h12345678);
        // AW ahead of W
        xact(1, 5'h0C, 32'h0BADCAFE, 4'hF, 0, 3, 0, 5'd0, 1, 0);
        chk_cfg();

        // ---- byte strobes ----
        xact(1, 5'h04, 32'hABCD0001, 4'hF, 0, 0, 0, 5'd0, 0, 0);
        xact(1, 5'h04, 32'hFFFFFFFF, 4'b0101, 0, 0, 0, 5'd0, 0, 0);
        chk("strobe_cfg_reg1", cfg_reg1, 32'hABFF00FF);
        xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'h04, 0, 2);

        // ---- WSTRB = 0: response and strobe, data unchanged ----
        xact(1, 5'h04, 32'h55555555, 4'b0000, 0, 0, 0, 5'd0, 0, 0);
        chk("nostrb_cfg_reg1", cfg_reg1, 32'hABFF00FF);

        // ---- write/read collision on reg0 ----
        xact(1, 5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0, 5'd0, 0, 0);
        xact(1, 5'h00, 32'hCAFEF00D, 4'hF, 0, 0, 1, 5'h00, 0, 0);
        xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'h00, 0, 0);
        chk_cfg();

        // ---- out-of-range slots ----
        xact(1, 5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 5'd0, 0, 0);
        xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'h10, 0, 0);
        xact(1, 5'h1F, 32'h01234567, 4'hF, 2, 0, 1, 5'h1C, 0, 1);
        chk_cfg();

        // ---- randomized traffic ----
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [4:0] a;
            kind = int'($urandom_range(0, 2));
            a = 5'($urandom_range(0, 31));
            if (kind == 0)
                xact(1, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 0, 5'd0, int'($urandom_range(0, 2)), 0);
            else if (kind == 1)
                xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, a, 0, int'($urandom_range(0, 2)));
            else
                xact(1, a, $urandom, 4'($urandom_range(0, 15)), 0, 0, 1,
                     5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            chk_cfg();
        end

        // ---- reset with responses pending ----
        xact(1, 5'h04, 32'h5A5A5A5A, 4'hF, 0, 0, 1, 5'h08, -1, -1);
        @(negedge clk);
        chk("pending_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        chk("pending_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        chk("midrst_cfg", cfg_reg0 | cfg_reg1 | cfg_reg2 | cfg_reg3 | {28'd0, cfg_wr_stb}, 32'd0);
        bq.delete();
        rq.delete();
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        xact(0, 5'd0, 32'd0, 4'd0, 0, 0, 1, 5'h04, 0, 0);
        xact(1, 5'h0C, 32'h600DF00D, 4'hF, 0, 0, 0, 5'd0, 0, 0);
        chk_cfg();

        repeat (4) @(posedge clk);
        chk("b_left_over", bq.size(), 32'd0);
        chk("r_left_over", rq.size(), 32'd0);
        chk("stb_left_over", sq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ce_input_buf_s_axi_regs.md
# ce_input_buf_s_axi_regs

AXI4-Lite responder (slave) register bank for the CE input buffer IP: it accepts single-beat writes and reads from the S00_AXI master and holds four 32-bit control registers at base+0x0/0x4/0x8/0xC. The register contents drive the CE input buffer datapath as static configuration. A one-cycle strobe flags each committed write.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots, slots 0-3 implemented.

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic on the rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; bits [1:0] ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; WSTRB[i] gates WDATA[8i+7:8i].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; bits [1:0] ignored.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- cfg_reg0 .. cfg_reg3  out  32 each  current register contents.
- cfg_wr_stb  out  4  one-hot, one-cycle pulse: bit i set in the cycle after register i commits a write.

## Operation
- Reset: all outputs 0, all registers 0x00000000, AW/W holding buffers empty. The ARESET assertion clears everything immediately, including in-flight transactions; a pending BVALID/RVALID is dropped.
- Word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2].
- Write path: AW and W are independent. Each has a one-entry holding buffer.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - Handshake order is free: AW first, W first, or both in the same cycle.
  - Commit edge: the first edge at which both address and data are available, either held or handshaking that cycle.
  - At the commit edge: byte-masked update of the indexed register; buffers cleared; BVALID set; cfg_wr_stb[index] set for one cycle.
  - BVALID holds with a stable BRESP until BREADY; it clears on the BVALID&&BREADY edge.
- Read path: ARREADY = !RVALID.
  - On the AR handshake edge, RDATA, RRESP and RVALID are registered.
  - RDATA/RRESP hold stable until RREADY; RVALID clears on the RVALID&&RREADY edge.
- Unimplemented index (4-7): writes change no register and produce no strobe; reads return 0x00000000. BRESP/RRESP are set per Configuration.
- Simultaneous write commit and read of the same register on one edge: the read returns the pre-write value.
- WSTRB = 0: the write completes with a normal response and a strobe, but register data is unchanged.

## Timing
- Write latency: AW and W handshaken on edge N → BVALID high from edge N; register value and cfg_reg visible after N; cfg_wr_stb high for the cycle after N.
- Write split: AW on edge N, W on edge N+k → commit on edge N+k.
- Write throughput: one write per 2 cycles with BREADY tied high.
- Read latency: AR on edge N → RVALID/RDATA valid from edge N.
- Read throughput: one read per 2 cycles with RREADY tied high.
- No combinational path from any input to any output except the READY signals, which depend only on internal state.

## Configuration
- CE_REGS_SLVERR_EN defined: accesses to unimplemented indices return SLVERR (2'b10) on BRESP/RRESP.
- CE_REGS_SLVERR_EN undefined: all accesses return OKAY (2'b00).
- The macro does not affect implemented registers.

## Test plan
- Reset: hold ARESET 500 ns → all cfg_reg = 0, all READY/VALID outputs 0 during reset; reads of 0x0-0xC after release return 0x00000000, OKAY.
- Sequential write/read: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, reading back each → each reads back equal with OKAY; cfg_wr_stb pulses 0001, 0010, 0100, 1000.
- Split channels: W 0x12345678 issued 5 cycles before AW 0x8 → single commit at the AW edge; cfg_reg2 = 0x12345678; BVALID held for 3 cycles while BREADY is low.
- Byte strobes: reg1 = 0xABCD0001, then write 0xFFFFFFFF with WSTRB = 4'b0101 → reg1 = 0xABFF00FF.
- Collision: reg0 = 0x0101FFFF; write 0xCAFEF00D to 0x0 and read 0x0 on the same edge → read returns 0x0101FFFF; a following read returns 0xCAFEF00D.
- Out of range: write 0xDEADBEEF to 0x10, then read 0x10 → regs 0-3 unchanged, no strobe, RDATA 0; response SLVERR with CE_REGS_SLVERR_EN defined, OKAY without it.
